// File: rtl/aurora_rx_frame_buffer_if.sv
// aurora_rx_frame_buffer_if
// Bundles the Aurora RX AXI-stream beat inputs, the programmed-I/O pop
// port and the status outputs of aurora_rx_frame_buffer.
//   slave  : the frame buffer (consumes rx_*/rd_pop/clear_err, drives the rest)
//   master : the surrounding logic (drives rx_*/rd_pop/clear_err)
// Signals:
//   rx_data[31:0], rx_tvalid, rx_tlast, rx_tkeep[3:0] : RX beat (no tready)
//   rd_pop, clear_err                                 : readback controls
//   rd_data[31:0], rd_last, rd_valid                  : popped word
//   word_cnt, frame_cnt, empty, full                  : occupancy status
//   overflow_sticky, drop_cnt[15:0]                   : error status
interface aurora_rx_frame_buffer_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int FCNT_BITS  = 8
);
  logic [31:0]           rx_data;
  logic                  rx_tvalid;
  logic                  rx_tlast;
  logic [3:0]            rx_tkeep;
  logic                  rd_pop;
  logic                  clear_err;
  logic [31:0]           rd_data;
  logic                  rd_last;
  logic                  rd_valid;
  logic [DEPTH_LOG2:0]   word_cnt;
  logic [FCNT_BITS-1:0]  frame_cnt;
  logic                  empty;
  logic                  full;
  logic                  overflow_sticky;
  logic [15:0]           drop_cnt;

  modport slave (
    input  rx_data, rx_tvalid, rx_tlast, rx_tkeep, rd_pop, clear_err,
    output rd_data, rd_last, rd_valid, word_cnt, frame_cnt, empty, full,
           overflow_sticky, drop_cnt
  );

  modport master (
    output rx_data, rx_tvalid, rx_tlast, rx_tkeep, rd_pop, clear_err,
    input  rd_data, rd_last, rd_valid, word_cnt, frame_cnt, empty, full,
           overflow_sticky, drop_cnt
  );
endinterface

// File: rtl/aurora_rx_frame_buffer.sv
// aurora_rx_frame_buffer
// Receive-side frame buffer: stores Aurora RX beats into a 33-bit word FIFO
// ({last, data}), exposes a frame to the reader only after its tlast beat is
// stored, and rolls back whole frames that overflow or carry a bad tkeep.
// Ports:
//   io_clk : sole clock
//   reset  : synchronous, active-high
//   bus    : aurora_rx_frame_buffer_if.slave (RX beats, pop port, status)
module aurora_rx_frame_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int FCNT_BITS  = 8
) (
  input  logic                    io_clk,
  input  logic                    reset,
  aurora_rx_frame_buffer_if.slave bus
);
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(1) << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t               state, state_nx;
  logic [PTR_W-1:0]     rd_ptr, cmt_ptr, wr_ptr;
  logic [32:0]          mem [2**DEPTH_LOG2];
  logic [FCNT_BITS-1:0] frame_cnt_p1;
  logic                 ovf_p1;
  logic [15:0]          drop_cnt_p1;
  logic [31:0]          rd_data_p1;
  logic                 rd_last_p1;
  logic                 vld_p1;

  logic [PTR_W-1:0]     word_cnt;
  logic                 full, empty, beat_ok, accept, pop;
  logic                 wr_en, commit, drop_ev, drop_full;
  logic [32:0]          head;

  // Status is derived only from registered pointers, so a pop in this cycle
  // cannot make room for a write in this same cycle.
  assign word_cnt = cmt_ptr - rd_ptr;
  assign empty    = (word_cnt == '0);
  assign full     = ((wr_ptr - rd_ptr) == DEPTH_P);
  assign beat_ok  = bus.rx_tlast ? (bus.rx_tkeep != 4'h0) : (bus.rx_tkeep == 4'hF);
  assign accept   = bus.rx_tvalid && !full && beat_ok;
  assign pop      = bus.rd_pop && !empty;
  assign head     = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    drop_ev   = 1'b0;
    drop_full = 1'b0;
    case (state)
      IDLE, RECV: begin
        if (bus.rx_tvalid) begin
          if (accept) begin
            wr_en = 1'b1;
            if (bus.rx_tlast) begin
              commit   = 1'b1;
              state_nx = IDLE;
            end else begin
              state_nx = RECV;
            end
          end else begin
            drop_ev   = 1'b1;
            drop_full = full;
            state_nx  = bus.rx_tlast ? IDLE : DISCARD;
          end
        end
      end
      DISCARD: begin
        if (bus.rx_tvalid && bus.rx_tlast) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- capture stage: FIFO storage (data only, no reset) ----
  always_ff @(posedge io_clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {bus.rx_tlast, bus.rx_data};
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      cmt_ptr      <= '0;
      wr_ptr       <= '0;
      frame_cnt_p1 <= '0;
      ovf_p1       <= 1'b0;
      drop_cnt_p1  <= '0;
    end else begin
      state <= state_nx;
      if (wr_en)        wr_ptr <= wr_ptr + PTR_W'(1);
      else if (drop_ev) wr_ptr <= cmt_ptr;
      if (commit) cmt_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr  <= rd_ptr + PTR_W'(1);
      // A commit and a pop of a last word in the same cycle cancel out.
      case ({commit, pop && head[32]})
        2'b10:   frame_cnt_p1 <= frame_cnt_p1 + FCNT_BITS'(1);
        2'b01:   frame_cnt_p1 <= frame_cnt_p1 - FCNT_BITS'(1);
        default: frame_cnt_p1 <= frame_cnt_p1;
      endcase
      if (bus.clear_err) begin
        ovf_p1      <= 1'b0;
        drop_cnt_p1 <= '0;
      end else if (drop_ev) begin
        drop_cnt_p1 <= sat_inc16(drop_cnt_p1);
        if (drop_full) ovf_p1 <= 1'b1;
      end
    end
  end

  // ---- read stage: registered head word and one-cycle valid pulse ----
  always_ff @(posedge io_clk) begin
    if (reset) begin
      rd_data_p1 <= '0;
      rd_last_p1 <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= pop;
      if (pop) begin
        rd_data_p1 <= head[31:0];
        rd_last_p1 <= head[32];
      end
    end
  end

  assign bus.rd_data         = rd_data_p1;
  assign bus.rd_last         = rd_last_p1;
  assign bus.rd_valid        = vld_p1;
  assign bus.word_cnt        = word_cnt;
  assign bus.frame_cnt       = frame_cnt_p1;
  assign bus.empty           = empty;
  assign bus.full            = full;
  assign bus.overflow_sticky = ovf_p1;
  assign bus.drop_cnt        = drop_cnt_p1;
endmodule

// File: tb/tb_aurora_rx_frame_buffer.sv
// tb_aurora_rx_frame_buffer
// Directed bench for aurora_rx_frame_buffer (DEPTH_LOG2=4, FCNT_BITS=8).
module tb_aurora_rx_frame_buffer;
  logic io_clk = 1'b0;
  logic reset  = 1'b1;
  int   nvec   = 0;
  int   nerr   = 0;

  always #5 io_clk = ~io_clk;

  aurora_rx_frame_buffer_if #(.DEPTH_LOG2(4), .FCNT_BITS(8)) bus ();

  aurora_rx_frame_buffer #(.DEPTH_LOG2(4), .FCNT_BITS(8)) dut (
    .io_clk (io_clk),
    .reset  (reset),
    .bus    (bus)
  );

  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [3:0] k);
    bus.rx_data   = d;
    bus.rx_tlast  = l;
    bus.rx_tkeep  = k;
    bus.rx_tvalid = 1'b1;
    step();
    bus.rx_tvalid = 1'b0;
    bus.rx_tlast  = 1'b0;
  endtask

  task automatic pop1();
    bus.rd_pop = 1'b1;
    step();
    bus.rd_pop = 1'b0;
  endtask

  task automatic clr();
    bus.clear_err = 1'b1;
    step();
    bus.clear_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    nvec++; if (bus.rd_data !== 32'h0) begin nerr++; $display("FAIL reset.rd_data: got %h want 0", bus.rd_data); end
    nvec++; if (bus.rd_last !== 1'b0) begin nerr++; $display("FAIL reset.rd_last: got %b want 0", bus.rd_last); end
    nvec++; if (bus.rd_valid !== 1'b0) begin nerr++; $display("FAIL reset.rd_valid: got %b want 0", bus.rd_valid); end
    nvec++; if (bus.word_cnt !== 5'd0) begin nerr++; $display("FAIL reset.word_cnt: got %0d want 0", bus.word_cnt); end
    nvec++; if (bus.frame_cnt !== 8'd0) begin nerr++; $display("FAIL reset.frame_cnt: got %0d want 0", bus.frame_cnt); end
    nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL reset.empty: got %b want 1", bus.empty); end
    nvec++; if (bus.full !== 1'b0) begin nerr++; $display("FAIL reset.full: got %b want 0", bus.full); end
    nvec++; if (bus.overflow_sticky !== 1'b0) begin nerr++; $display("FAIL reset.ovf: got %b want 0", bus.overflow_sticky); end
    nvec++; if (bus.drop_cnt !== 16'd0) begin nerr++; $display("FAIL reset.drop_cnt: got %0d want 0", bus.drop_cnt); end
  endtask

  task automatic test_single_frame();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222; exp_d[2] = 32'h33333333;
    send(exp_d[0], 1'b0, 4'hF);
    send(exp_d[1], 1'b0, 4'hF);
    nvec++; if (bus.word_cnt !== 5'd0) begin nerr++; $display("FAIL single.uncommitted_cnt: got %0d want 0", bus.word_cnt); end
    send(exp_d[2], 1'b1, 4'hF);
    nvec++; if (bus.word_cnt !== 5'd3) begin nerr++; $display("FAIL single.word_cnt: got %0d want 3", bus.word_cnt); end
    nvec++; if (bus.frame_cnt !== 8'd1) begin nerr++; $display("FAIL single.frame_cnt: got %0d want 1", bus.frame_cnt); end
    nvec++; if (bus.empty !== 1'b0) begin nerr++; $display("FAIL single.not_empty: got %b want 0", bus.empty); end
    bus.rd_pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++; if (bus.rd_valid !== 1'b1) begin nerr++; $display("FAIL single.rd_valid[%0d]: got %b want 1", i, bus.rd_valid); end
      nvec++; if (bus.rd_data !== exp_d[i]) begin nerr++; $display("FAIL single.rd_data[%0d]: got %h want %h", i, bus.rd_data, exp_d[i]); end
      nvec++; if (bus.rd_last !== (i == 2)) begin nerr++; $display("FAIL single.rd_last[%0d]: got %b want %b", i, bus.rd_last, (i == 2)); end
    end
    bus.rd_pop = 1'b0;
    step();
    nvec++; if (bus.rd_valid !== 1'b0) begin nerr++; $display("FAIL single.rd_valid_drop: got %b want 0", bus.rd_valid); end
    nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL single.empty: got %b want 1", bus.empty); end
    nvec++; if (bus.frame_cnt !== 8'd0) begin nerr++; $display("FAIL single.frame_cnt_end: got %0d want 0", bus.frame_cnt); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 14; i++) send(32'h0A00_0000 + i, (i == 13), 4'hF);
    nvec++; if (bus.word_cnt !== 5'd14) begin nerr++; $display("FAIL ovf.preload: got %0d want 14", bus.word_cnt); end
    send(32'hBBBB_0000, 1'b0, 4'hF);
    send(32'hBBBB_0001, 1'b0, 4'hF);
    nvec++; if (bus.full !== 1'b1) begin nerr++; $display("FAIL ovf.full: got %b want 1", bus.full); end
    send(32'hBBBB_0002, 1'b0, 4'hF);
    send(32'hBBBB_0003, 1'b1, 4'hF);
    nvec++; if (bus.word_cnt !== 5'd14) begin nerr++; $display("FAIL ovf.word_cnt: got %0d want 14", bus.word_cnt); end
    nvec++; if (bus.drop_cnt !== 16'd1) begin nerr++; $display("FAIL ovf.drop_cnt: got %0d want 1", bus.drop_cnt); end
    nvec++; if (bus.overflow_sticky !== 1'b1) begin nerr++; $display("FAIL ovf.sticky: got %b want 1", bus.overflow_sticky); end
    nvec++; if (bus.full !== 1'b0) begin nerr++; $display("FAIL ovf.rollback_full: got %b want 0", bus.full); end
    nvec++; if (bus.frame_cnt !== 8'd1) begin nerr++; $display("FAIL ovf.frame_cnt: got %0d want 1", bus.frame_cnt); end
    bus.rd_pop = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      nvec++; if (bus.rd_data !== 32'h0A00_0000 + i) begin nerr++; $display("FAIL ovf.pop_data[%0d]: got %h want %h", i, bus.rd_data, 32'h0A00_0000 + i); end
    end
    bus.rd_pop = 1'b0;
    send(32'hCCCC_0000, 1'b0, 4'hF);
    send(32'hCCCC_0001, 1'b1, 4'hF);
    nvec++; if (bus.word_cnt !== 5'd2) begin nerr++; $display("FAIL ovf.after_word_cnt: got %0d want 2", bus.word_cnt); end
    nvec++; if (bus.frame_cnt !== 8'd1) begin nerr++; $display("FAIL ovf.after_frame_cnt: got %0d want 1", bus.frame_cnt); end
    pop1();
    nvec++; if (bus.rd_data !== 32'hCCCC_0000) begin nerr++; $display("FAIL ovf.after_d0: got %h want cccc0000", bus.rd_data); end
    pop1();
    nvec++; if (bus.rd_data !== 32'hCCCC_0001 || bus.rd_last !== 1'b1) begin nerr++; $display("FAIL ovf.after_d1: got %h/%b want cccc0001/1", bus.rd_data, bus.rd_last); end
    clr();
    nvec++; if (bus.drop_cnt !== 16'd0 || bus.overflow_sticky !== 1'b0) begin nerr++; $display("FAIL ovf.clear: got %0d/%b want 0/0", bus.drop_cnt, bus.overflow_sticky); end
  endtask

  task automatic test_bad_tkeep();
    send(32'hD000_0000, 1'b1, 4'hF);
    send(32'hD100_0000, 1'b0, 4'hF);
    send(32'hD100_0001, 1'b0, 4'h7);
    send(32'hD100_0002, 1'b1, 4'hF);
    nvec++; if (bus.drop_cnt !== 16'd1) begin nerr++; $display("FAIL tkeep.drop_cnt: got %0d want 1", bus.drop_cnt); end
    nvec++; if (bus.overflow_sticky !== 1'b0) begin nerr++; $display("FAIL tkeep.sticky: got %b want 0", bus.overflow_sticky); end
    nvec++; if (bus.word_cnt !== 5'd1) begin nerr++; $display("FAIL tkeep.word_cnt: got %0d want 1", bus.word_cnt); end
    // Partial tkeep is legal on a last beat; all-zero tkeep is not.
    send(32'hD200_0000, 1'b1, 4'h1);
    nvec++; if (bus.word_cnt !== 5'd2) begin nerr++; $display("FAIL tkeep.partial_last: got %0d want 2", bus.word_cnt); end
    send(32'hD300_0000, 1'b1, 4'h0);
    nvec++; if (bus.drop_cnt !== 16'd2 || bus.word_cnt !== 5'd2) begin nerr++; $display("FAIL tkeep.zero_last: got %0d/%0d want 2/2", bus.drop_cnt, bus.word_cnt); end
    pop1();
    nvec++; if (bus.rd_data !== 32'hD000_0000) begin nerr++; $display("FAIL tkeep.pop0: got %h want d0000000", bus.rd_data); end
    pop1();
    nvec++; if (bus.rd_data !== 32'hD200_0000) begin nerr++; $display("FAIL tkeep.pop1: got %h want d2000000", bus.rd_data); end
    clr();
  endtask

  task automatic test_simultaneous();
    send(32'hA1A1_A1A1, 1'b1, 4'hF);
    nvec++; if (bus.frame_cnt !== 8'd1) begin nerr++; $display("FAIL sim.pre_frame_cnt: got %0d want 1", bus.frame_cnt); end
    bus.rd_pop = 1'b1;
    send(32'hB2B2_B2B2, 1'b1, 4'hF);
    bus.rd_pop = 1'b0;
    nvec++; if (bus.frame_cnt !== 8'd1) begin nerr++; $display("FAIL sim.frame_cnt: got %0d want 1", bus.frame_cnt); end
    nvec++; if (bus.rd_data !== 32'hA1A1_A1A1 || bus.rd_last !== 1'b1) begin nerr++; $display("FAIL sim.rd: got %h/%b want a1a1a1a1/1", bus.rd_data, bus.rd_last); end
    nvec++; if (bus.word_cnt !== 5'd1) begin nerr++; $display("FAIL sim.word_cnt: got %0d want 1", bus.word_cnt); end
    pop1();
    nvec++; if (bus.rd_data !== 32'hB2B2_B2B2 || bus.rd_valid !== 1'b1) begin nerr++; $display("FAIL sim.pop_b: got %h/%b want b2b2b2b2/1", bus.rd_data, bus.rd_valid); end
    pop1();
    nvec++; if (bus.rd_valid !== 1'b0) begin nerr++; $display("FAIL sim.pop_empty_valid: got %b want 0", bus.rd_valid); end
    nvec++; if (bus.rd_data !== 32'hB2B2_B2B2) begin nerr++; $display("FAIL sim.pop_empty_hold: got %h want b2b2b2b2", bus.rd_data); end
    nvec++; if (bus.frame_cnt !== 8'd0 || bus.empty !== 1'b1) begin nerr++; $display("FAIL sim.end: got %0d/%b want 0/1", bus.frame_cnt, bus.empty); end
  endtask

  task automatic test_wrap();
    int rcv = 0;
    logic [31:0] exp_d;
    for (int cyc = 0; cyc < 300 && rcv < 80; cyc++) begin
      if (cyc < 80) begin
        bus.rx_data   = 32'hC000_0000 + cyc;
        bus.rx_tlast  = (cyc % 2) == 1;
        bus.rx_tkeep  = 4'hF;
        bus.rx_tvalid = 1'b1;
      end else begin
        bus.rx_tvalid = 1'b0;
        bus.rx_tlast  = 1'b0;
      end
      bus.rd_pop = 1'b1;
      step();
      if (bus.rd_valid) begin
        exp_d = 32'hC000_0000 + rcv;
        nvec++; if (bus.rd_data !== exp_d || bus.rd_last !== ((rcv % 2) == 1)) begin nerr++; $display("FAIL wrap.word[%0d]: got %h/%b want %h/%b", rcv, bus.rd_data, bus.rd_last, exp_d, (rcv % 2) == 1); end
        rcv++;
      end
    end
    bus.rx_tvalid = 1'b0;
    bus.rx_tlast  = 1'b0;
    bus.rd_pop    = 1'b0;
    step();
    nvec++; if (rcv != 80) begin nerr++; $display("FAIL wrap.count: got %0d want 80", rcv); end
    nvec++; if (bus.empty !== 1'b1 || bus.frame_cnt !== 8'd0) begin nerr++; $display("FAIL wrap.end: got %b/%0d want 1/0", bus.empty, bus.frame_cnt); end
    nvec++; if (bus.drop_cnt !== 16'd0) begin nerr++; $display("FAIL wrap.drops: got %0d want 0", bus.drop_cnt); end
  endtask

  task automatic test_reset_midframe();
    send(32'hE000_0000, 1'b1, 4'hF);
    send(32'hE000_0001, 1'b1, 4'hF);
    pop1();
    send(32'hE100_0000, 1'b1, 4'h0);
    send(32'hE200_0000, 1'b0, 4'hF);
    send(32'hE200_0001, 1'b0, 4'hF);
    nvec++; if (bus.drop_cnt !== 16'd1 || bus.frame_cnt !== 8'd1) begin nerr++; $display("FAIL rstmid.pre: got %0d/%0d want 1/1", bus.drop_cnt, bus.frame_cnt); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    nvec++; if (bus.rd_data !== 32'h0 || bus.rd_last !== 1'b0 || bus.rd_valid !== 1'b0) begin nerr++; $display("FAIL rstmid.rd: got %h/%b/%b want 0/0/0", bus.rd_data, bus.rd_last, bus.rd_valid); end
    nvec++; if (bus.word_cnt !== 5'd0 || bus.frame_cnt !== 8'd0) begin nerr++; $display("FAIL rstmid.cnt: got %0d/%0d want 0/0", bus.word_cnt, bus.frame_cnt); end
    nvec++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin nerr++; $display("FAIL rstmid.flags: got %b/%b want 1/0", bus.empty, bus.full); end
    nvec++; if (bus.drop_cnt !== 16'd0 || bus.overflow_sticky !== 1'b0) begin nerr++; $display("FAIL rstmid.err: got %0d/%b want 0/0", bus.drop_cnt, bus.overflow_sticky); end
    send(32'hF000_0000, 1'b0, 4'hF);
    send(32'hF000_0001, 1'b1, 4'hF);
    nvec++; if (bus.frame_cnt !== 8'd1 || bus.word_cnt !== 5'd2) begin nerr++; $display("FAIL rstmid.fresh: got %0d/%0d want 1/2", bus.frame_cnt, bus.word_cnt); end
    pop1();
    nvec++; if (bus.rd_data !== 32'hF000_0000 || bus.rd_last !== 1'b0) begin nerr++; $display("FAIL rstmid.pop0: got %h/%b want f0000000/0", bus.rd_data, bus.rd_last); end
    pop1();
    nvec++; if (bus.rd_data !== 32'hF000_0001 || bus.rd_last !== 1'b1) begin nerr++; $display("FAIL rstmid.pop1: got %h/%b want f0000001/1", bus.rd_data, bus.rd_last); end
  endtask

  initial begin
    bus.rx_data   = '0;
    bus.rx_tvalid = 1'b0;
    bus.rx_tlast  = 1'b0;
    bus.rx_tkeep  = 4'h0;
    bus.rd_pop    = 1'b0;
    bus.clear_err = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_bad_tkeep();
    test_simultaneous();
    test_wrap();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
